// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, word constants and the branch displacement helper.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_INCR   = 32'd4;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    // Signed word offset turned into a byte displacement: sext(offset) << 2.
    function automatic logic [WORD_W-1:0] branch_disp(input logic [7:0] offset);
        return {{(WORD_W - 10){offset[7]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC adders: sequential PC+4 and the taken-branch target.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] PC,
    input  logic              BRANCH_TAKEN,
    input  logic [7:0]        OFFSET,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] next_pc
);

    always_comb begin
        pc_plus4 = PC + PC_INCR;
        next_pc  = BRANCH_TAKEN ? pc_plus4 + branch_disp(OFFSET) : pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the READ/BUSYWAIT handshake and holds the fetched word.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       MAX_WAIT = 16,
    parameter int unsigned       CNT_W    = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              BRANCH_TAKEN,
    input  logic [7:0]        OFFSET,
    input  logic              IMEM_BUSYWAIT,
    input  logic [WORD_W-1:0] IMEM_READDATA,
    output logic              IMEM_READ,
    output logic [WORD_W-1:0] IMEM_ADDRESS,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] INSTRUCTION,
    output logic              INSTR_VALID,
    output logic              FETCH_BUSY,
    output logic              FETCH_ERROR
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    fetch_state_e      state;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] instr_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              imem_read_q;
    logic              instr_valid_q;
    logic              fetch_busy_q;
    logic              fetch_error_q;

    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] next_pc;
    logic              unused_pc_plus4;

    fetch_next_pc u_next_pc (
        .PC           (pc_q),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .OFFSET       (OFFSET),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    assign unused_pc_plus4 = ^pc_plus4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            wait_cnt      <= '0;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_busy_q  <= 1'b1;
            fetch_error_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state       <= S_FETCH;
                    imem_read_q <= 1'b1;
                end
                S_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        instr_q       <= IMEM_READDATA;
                        instr_valid_q <= 1'b1;
                        wait_cnt      <= '0;
                        imem_read_q   <= 1'b0;
                        fetch_busy_q  <= 1'b0;
                        state         <= S_ISSUE;
                    end else begin
                        if (wait_cnt != MAX_CNT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        // The edge that takes the count to MAX_WAIT raises the sticky error.
                        if (wait_cnt >= MAX_CNT - 1'b1) begin
                            fetch_error_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!STALL) begin
                        pc_q          <= next_pc;
                        instr_valid_q <= 1'b0;
                        imem_read_q   <= 1'b1;
                        fetch_busy_q  <= 1'b1;
                        state         <= S_FETCH;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    imem_read_q  <= 1'b0;
                    fetch_busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign IMEM_READ    = imem_read_q;
    assign IMEM_ADDRESS = pc_q;
    assign PC           = pc_q;
    assign INSTRUCTION  = instr_q;
    assign INSTR_VALID  = instr_valid_q;
    assign FETCH_BUSY   = fetch_busy_q;
    assign FETCH_ERROR  = fetch_error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed boundary cases plus a randomized
// scoreboard run against a PC/memory reference model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  offset;
    logic        imem_busywait;
    logic [31:0] imem_readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    bit   sb_on = 1'b0;
    bit   prev_valid = 1'b0;

    instruction_fetch_unit dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .STALL         (stall),
        .BRANCH_TAKEN  (branch_taken),
        .OFFSET        (offset),
        .IMEM_BUSYWAIT (imem_busywait),
        .IMEM_READDATA (imem_readdata),
        .IMEM_READ     (imem_read),
        .IMEM_ADDRESS  (imem_address),
        .PC            (pc),
        .INSTRUCTION   (instruction),
        .INSTR_VALID   (instr_valid),
        .FETCH_BUSY    (fetch_busy),
        .FETCH_ERROR   (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0011;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: data is garbage while busy.
    always_comb imem_readdata = imem_busywait ? 32'hDEAD_BEEF : mem_word(imem_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Branch target from the rules: pc + 4 + 4*signed(offset), 32-bit wrap.
    function automatic logic [31:0] model_next(input logic [31:0] p, input bit bt,
                                               input logic [7:0] off);
        int o;
        o = int'($signed(off));
        return p + 32'd4 + (bt ? 32'(o * 4) : 32'd0);
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_imem_read", {31'b0, imem_read}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_error", {31'b0, fetch_error}, 32'd0);
        check("rst_busy", {31'b0, fetch_busy}, 32'd1);
    endtask

    task automatic goto_issue();
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) check("issue_timeout", {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic consume(input bit bt, input logic [7:0] off);
        goto_issue();
        branch_taken = bt;
        offset       = off;
        stall        = 1'b0;
        @(posedge clk);
        #1;
        stall        = 1'b1;
        branch_taken = 1'b0;
        offset       = 8'h00;
    endtask

    // Scoreboard monitor: each newly presented instruction must match the model's queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (sb_on && instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h, no instruction was expected", pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_instr", instruction, e.instr);
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model_pc;
        int          busy_run;

        rst_n = 1'b0;
        stall = 1'b1;
        branch_taken = 1'b0;
        offset = 8'h00;
        imem_busywait = 1'b0;

        // Reset, first fetch with zero-wait memory.
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        check("t1_read_rise", {31'b0, imem_read}, 32'd1);
        check("t1_addr", imem_address, 32'h0);
        check("t1_busy_fetch", {31'b0, fetch_busy}, 32'd1);
        @(posedge clk); #1;
        check("t1_valid", {31'b0, instr_valid}, 32'd1);
        check("t1_instr", instruction, 32'h0000_0011);
        check("t1_busy_issue", {31'b0, fetch_busy}, 32'd0);
        check("t1_read_fall", {31'b0, imem_read}, 32'd0);
        @(posedge clk); #1;
        stall = 1'b1;
        check("t1_pc4", pc, 32'h4);
        check("t1_valid_clr", {31'b0, instr_valid}, 32'd0);

        // Redirects, self-loop, most-negative offset and wrap-around.
        repeat (3) consume(1'b0, 8'h00);
        check("t2_pc10", pc, 32'h10);
        consume(1'b1, 8'h03);
        check("t2_fwd", imem_address, 32'h20);
        consume(1'b1, 8'hFB);
        check("t2_back10", pc, 32'h10);
        consume(1'b1, 8'hFE);
        check("t2_neg", imem_address, 32'h0C);
        consume(1'b1, 8'hFF);
        check("t2_selfloop", pc, 32'h0C);
        consume(1'b1, 8'h80);
        check("t2_min_off", pc, 32'hFFFF_FE10);
        consume(1'b1, 8'h7A);
        check("t6_top", pc, 32'hFFFF_FFFC);
        consume(1'b0, 8'h00);
        check("t6_wrap", imem_address, 32'h0);

        // Three busywait cycles.
        goto_issue();
        imem_busywait = 1'b1;
        consume(1'b0, 8'h00);
        check("t3_read_c0", {31'b0, imem_read}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t3_read_hold", {31'b0, imem_read}, 32'd1);
            check("t3_addr_hold", imem_address, 32'h4);
            check("t3_no_valid", {31'b0, instr_valid}, 32'd0);
            check("t3_instr_hold", instruction, 32'h0000_0011);
        end
        imem_busywait = 1'b0;
        @(posedge clk); #1;
        check("t3_capture_valid", {31'b0, instr_valid}, 32'd1);
        check("t3_capture", instruction, mem_word(32'h4));

        // MAX_WAIT busywait cycles raise the sticky error.
        goto_issue();
        imem_busywait = 1'b1;
        consume(1'b0, 8'h00);
        repeat (15) @(posedge clk);
        #1;
        check("t3_err_early", {31'b0, fetch_error}, 32'd0);
        @(posedge clk); #1;
        check("t3_err_set", {31'b0, fetch_error}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_still_wait", {31'b0, imem_read}, 32'd1);
        imem_busywait = 1'b0;
        @(posedge clk); #1;
        check("t3_err_capture", instruction, mem_word(32'h8));
        check("t3_err_sticky", {31'b0, fetch_error}, 32'd1);

        // Stall with BRANCH_TAKEN toggling freezes PC and INSTRUCTION.
        goto_issue();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            branch_taken = ~branch_taken;
            offset = 8'($urandom);
            @(posedge clk); #1;
            check("t4_pc_frozen", pc, 32'h8);
            check("t4_instr_frozen", instruction, mem_word(32'h8));
            check("t4_valid_held", {31'b0, instr_valid}, 32'd1);
        end
        branch_taken = 1'b0;
        consume(1'b1, 8'h02);
        check("t4_redirect", pc, 32'h14);

        // Asynchronous reset in the middle of a fetch.
        imem_busywait = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_read_drop", {31'b0, imem_read}, 32'd0);
        check("t5_pc_reset", pc, 32'h0);
        check("t5_err_clear", {31'b0, fetch_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_busywait = 1'b0;
        @(posedge clk); #1;
        check("t5_refetch_read", {31'b0, imem_read}, 32'd1);
        check("t5_refetch_addr", imem_address, 32'h0);
        @(posedge clk); #1;
        check("t5_refetch_valid", {31'b0, instr_valid}, 32'd1);
        check("t5_refetch_instr", instruction, 32'h0000_0011);

        // Randomized run against the reference model.
        do_reset();
        exp_q.delete();
        model_pc = 32'h0;
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        sb_on = 1'b1;
        busy_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stall = ($urandom_range(3) == 0);
            branch_taken = ($urandom_range(1) == 1);
            offset = 8'($urandom);
            if (busy_run < 4 && $urandom_range(2) == 0) begin
                imem_busywait = 1'b1;
                busy_run++;
            end else begin
                imem_busywait = 1'b0;
                busy_run = 0;
            end
            if (instr_valid && !stall) begin
                model_pc = model_next(model_pc, branch_taken, offset);
                exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            end
        end
        stall = 1'b1;
        imem_busywait = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        check("sb_no_error", {31'b0, fetch_error}, 32'd0);
        sb_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
